// File: rtl/pc_redirect_unit.sv
// PC register and control-flow redirect stage for the five-stage MIPS pipeline.
// Picks the next fetch address, flushes IF/ID on taken redirects, keeps branch stats.
module pc_redirect_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Stall,
  input  logic [31:0]      Instruction,
  input  logic [31:0]      IDPC4,
  input  logic [31:0]      RegA,
  input  logic             Branch,
  input  logic             Output,
  output logic [31:0]      PC,
  output logic [31:0]      PCPlus4,
  output logic             Flush,
  output logic             LinkWrite,
  output logic [31:0]      LinkAddr,
  output logic             Fault,
  output logic [CNT_W-1:0] BranchCount,
  output logic [CNT_W-1:0] TakenCount
);

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_HALT
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [31:0]      r_pc;
  logic [31:0]      w_pc_nxt;
  logic             r_fault;
  logic             w_fault_set;
  logic [CNT_W-1:0] r_bcnt;
  logic [CNT_W-1:0] r_tcnt;
  logic             w_inc_b;
  logic             w_inc_t;

  logic [5:0]       w_opcode;
  logic [5:0]       w_funct;
  logic             w_is_j;
  logic             w_is_jal;
  logic             w_is_jr;
  logic             w_taken;
  logic             w_aligned;
  logic [31:0]      w_br_tgt;
  logic [31:0]      w_j_tgt;
  logic [31:0]      w_target;

  assign w_opcode = Instruction[31:26];
  assign w_funct  = Instruction[5:0];
  assign w_is_jal = (w_opcode == 6'b000011);
  assign w_is_j   = (w_opcode == 6'b000010) | w_is_jal;
  assign w_is_jr  = (w_opcode == 6'b000000) &
                    (w_funct == 6'b001000);
  assign w_taken  = Branch & Output;

  assign w_br_tgt = IDPC4 + {{14{Instruction[15]}},
                             Instruction[15:0], 2'b00};
  assign w_j_tgt  = {IDPC4[31:28], Instruction[25:0], 2'b00};

  always_comb begin
    w_target = w_br_tgt;
    unique case (1'b1)
      w_is_j:  w_target = w_j_tgt;
      w_is_jr: w_target = RegA;
      default: w_target = w_br_tgt;
    endcase
  end

  assign w_aligned = (w_target[1:0] == 2'b00);

  assign PC          = r_pc;
  assign PCPlus4     = r_pc + 32'd4;
  assign LinkAddr    = IDPC4;
  assign Fault       = r_fault;
  assign BranchCount = r_bcnt;
  assign TakenCount  = r_tcnt;

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_fault_set = 1'b0;
    w_inc_b     = 1'b0;
    w_inc_t     = 1'b0;
    Flush       = 1'b0;
    LinkWrite   = 1'b0;
    case (r_state)
      S_BOOT: begin
        Flush       = 1'b1;
        w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (!Stall) begin
          if (w_taken) begin
            Flush = 1'b1;
            if (w_aligned) begin
              w_pc_nxt  = w_target;
              w_inc_b   = 1'b1;
              w_inc_t   = 1'b1;
              LinkWrite = w_is_jal;
            end else begin
              // misaligned target: freeze rather than fetch garbage
              w_fault_set = 1'b1;
              w_state_nxt = S_HALT;
            end
          end else begin
            w_pc_nxt = PCPlus4;
            w_inc_b  = Branch;
          end
        end
      end
      S_HALT: begin
        Flush = 1'b1;
      end
      default: begin
        Flush       = 1'b1;
        w_state_nxt = S_BOOT;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_state <= S_BOOT;
      r_pc    <= RESET_PC;
      r_fault <= 1'b0;
      r_bcnt  <= '0;
      r_tcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      if (w_fault_set) r_fault <= 1'b1;
      if (w_inc_b && !(&r_bcnt)) r_bcnt <= r_bcnt + CNT_W'(1);
      if (w_inc_t && !(&r_tcnt)) r_tcnt <= r_tcnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Bench for pc_redirect_unit: per-cycle model compare plus directed literal checks.
// A second instance with RESET_PC=FFFF_FFFC covers the PC+4 wrap.
module tb_pc_redirect_unit;

  localparam logic [31:0] I_BNE  = 32'h1422_FFFE;
  localparam logic [31:0] I_JAL  = 32'h0C00_0100;
  localparam logic [31:0] I_J200 = 32'h0800_0080;
  localparam logic [31:0] I_JR   = 32'h03E0_0008;
  localparam int MB = 0, MR = 1, MH = 2;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic        Rst, rst2, Stall, Branch, Out;
  logic        b0 = 1'b0;
  logic [31:0] Instr, IDPC4, RegA;

  logic [31:0] pc, pcp4, la;
  logic        flush, lw, fault;
  logic [15:0] bc, tc;
  logic [31:0] pc2, pcp42, la2;
  logic        flush2, lw2, fault2;
  logic [15:0] bc2, tc2;

  pc_redirect_unit #(.RESET_PC(32'h0), .CNT_W(16)) dut (
    .Clk(Clk), .Rst(Rst), .Stall(Stall), .Instruction(Instr),
    .IDPC4(IDPC4), .RegA(RegA), .Branch(Branch), .Output(Out),
    .PC(pc), .PCPlus4(pcp4), .Flush(flush), .LinkWrite(lw),
    .LinkAddr(la), .Fault(fault), .BranchCount(bc), .TakenCount(tc)
  );

  pc_redirect_unit #(.RESET_PC(32'hFFFF_FFFC), .CNT_W(16)) dut2 (
    .Clk(Clk), .Rst(rst2), .Stall(Stall), .Instruction(Instr),
    .IDPC4(IDPC4), .RegA(RegA), .Branch(b0), .Output(Out),
    .PC(pc2), .PCPlus4(pcp42), .Flush(flush2), .LinkWrite(lw2),
    .LinkAddr(la2), .Fault(fault2), .BranchCount(bc2), .TakenCount(tc2)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] f_target(input logic [31:0] ins,
                                           input logic [31:0] pc4,
                                           input logic [31:0] ra);
    logic [31:0] off;
    if (ins[31:26] == 6'd2 || ins[31:26] == 6'd3)
      return {pc4[31:28], ins[25:0], 2'b00};
    if (ins[31:26] == 6'd0 && ins[5:0] == 6'd8)
      return ra;
    off = 32'(signed'(ins[15:0])) * 4;
    return pc4 + off;
  endfunction

  function automatic logic [15:0] f_sat(input logic [15:0] x);
    return (x == 16'hFFFF) ? x : x + 16'd1;
  endfunction

  // behavioural model
  int          m_st = MB;
  logic [31:0] m_pc = 32'h0;
  logic        m_fault = 1'b0;
  logic [15:0] m_bc = 16'h0, m_tc = 16'h0;

  always @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      m_st <= MB; m_pc <= 32'h0; m_fault <= 1'b0;
      m_bc <= 16'h0; m_tc <= 16'h0;
    end else if (m_st == MB) begin
      m_st <= MR;
    end else if (m_st == MR && !Stall) begin
      if (Branch && Out) begin
        if ((f_target(Instr, IDPC4, RegA) & 32'h3) == 0) begin
          m_pc <= f_target(Instr, IDPC4, RegA);
          m_bc <= f_sat(m_bc);
          m_tc <= f_sat(m_tc);
        end else begin
          m_fault <= 1'b1;
          m_st <= MH;
        end
      end else begin
        m_pc <= m_pc + 32'd4;
        if (Branch) m_bc <= f_sat(m_bc);
      end
    end
  end

  logic chk_en = 1'b0;
  always @(negedge Clk) begin
    if (chk_en) begin
      logic tk, e_fl, e_lw;
      tk   = (m_st == MR) && !Stall && Branch && Out;
      e_fl = (m_st != MR) || tk;
      e_lw = tk && ((f_target(Instr, IDPC4, RegA) & 32'h3) == 0) &&
             (Instr[31:26] == 6'd3);
      chk("m_pc", pc, m_pc);
      chk("m_pcp4", pcp4, m_pc + 32'd4);
      chk("m_flush", {31'b0, flush}, {31'b0, e_fl});
      chk("m_lw", {31'b0, lw}, {31'b0, e_lw});
      chk("m_la", la, IDPC4);
      chk("m_fault", {31'b0, fault}, {31'b0, m_fault});
      chk("m_bc", {16'b0, bc}, {16'b0, m_bc});
      chk("m_tc", {16'b0, tc}, {16'b0, m_tc});
    end
  end

  task automatic drive(input logic s, input logic b, input logic o,
                       input logic [31:0] ins, input logic [31:0] pc4,
                       input logic [31:0] ra);
    Stall = s; Branch = b; Out = o;
    Instr = ins; IDPC4 = pc4; RegA = ra;
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  initial begin
    Rst = 1'b0; rst2 = 1'b0;
    drive(0, 0, 0, 32'h0, 32'h0, 32'h0);
    #1;
    chk_en = 1'b1;
    chk("rst_flush", {31'b0, flush}, 32'd1);
    chk("rst_pc", pc, 32'h0);
    chk("rst_lw", {31'b0, lw}, 32'd0);
    chk("rst_bc", {16'b0, bc}, 32'd0);
    tick; tick;
    #2 Rst = 1'b1;
    #1 chk("boot_flush", {31'b0, flush}, 32'd1);
    tick;
    chk("run_pc0", pc, 32'h0);
    chk("run_flush0", {31'b0, flush}, 32'd0);
    tick; chk("pc4", pc, 32'h4);
    tick; chk("pc8", pc, 32'h8);
    tick; chk("pc12", pc, 32'hC);

    drive(0, 1, 1, I_BNE, 32'h40, 32'h0);
    #1 chk("bne_flush", {31'b0, flush}, 32'd1);
    tick;
    chk("bne_pc", pc, 32'h38);
    chk("bne_bc", {16'b0, bc}, 32'd1);
    chk("bne_tc", {16'b0, tc}, 32'd1);
    drive(0, 1, 0, I_BNE, 32'h44, 32'h0);
    #1 chk("nt_flush", {31'b0, flush}, 32'd0);
    tick;
    chk("nt_pc", pc, 32'h3C);
    chk("nt_bc", {16'b0, bc}, 32'd2);
    chk("nt_tc", {16'b0, tc}, 32'd1);

    drive(0, 1, 1, I_JAL, 32'h1000_0010, 32'h0);
    #1;
    chk("jal_lw", {31'b0, lw}, 32'd1);
    chk("jal_la", la, 32'h1000_0010);
    tick;
    chk("jal_pc", pc, 32'h1000_0400);
    drive(0, 1, 1, I_JR, 32'h1000_0404, 32'h1000_0010);
    #1 chk("jr_lw", {31'b0, lw}, 32'd0);
    tick;
    chk("jr_pc", pc, 32'h1000_0010);

    drive(1, 1, 1, I_J200, 32'h1000_0014, 32'h0);
    repeat (3) begin
      #1 chk("stall_flush", {31'b0, flush}, 32'd0);
      tick;
      chk("stall_pc", pc, 32'h1000_0010);
      chk("stall_tc", {16'b0, tc}, 32'd3);
    end
    Stall = 1'b0;
    #1 chk("unstall_flush", {31'b0, flush}, 32'd1);
    tick;
    chk("unstall_pc", pc, 32'h1000_0200);
    chk("unstall_bc", {16'b0, bc}, 32'd5);
    chk("unstall_tc", {16'b0, tc}, 32'd4);

    drive(0, 1, 1, I_JR, 32'h1000_0204, 32'h0000_0102);
    #1 chk("flt_flush", {31'b0, flush}, 32'd1);
    tick;
    chk("flt_fault", {31'b0, fault}, 32'd1);
    chk("flt_pc", pc, 32'h1000_0200);
    drive(0, 1, 1, I_J200, 32'h1000_0204, 32'h0);
    repeat (3) begin
      #1 chk("halt_flush", {31'b0, flush}, 32'd1);
      tick;
      chk("halt_pc", pc, 32'h1000_0200);
      chk("halt_bc", {16'b0, bc}, 32'd5);
    end
    #2 Rst = 1'b0;
    #1;
    chk("clr_fault", {31'b0, fault}, 32'd0);
    chk("clr_pc", pc, 32'h0);
    tick;
    #2 Rst = 1'b1;
    tick;

    drive(0, 1, 1, I_JR, 32'h0, 32'h100);
    repeat (65540) tick;
    chk("sat_bc", {16'b0, bc}, 32'hFFFF);
    chk("sat_tc", {16'b0, tc}, 32'hFFFF);
    chk("sat_pc", pc, 32'h100);

    drive(0, 0, 0, 32'h0, 32'h0, 32'h0);
    #2 rst2 = 1'b1;
    #1;
    chk("w_boot_pc", pc2, 32'hFFFF_FFFC);
    chk("w_boot_flush", {31'b0, flush2}, 32'd1);
    tick;
    chk("w_pc_top", pc2, 32'hFFFF_FFFC);
    chk("w_pcp4", pcp42, 32'h0);
    chk("w_flush", {31'b0, flush2}, 32'd0);
    tick; chk("w_pc_wrap", pc2, 32'h0);
    tick; chk("w_pc_4", pc2, 32'h4);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_redirect_unit.md
# pc_redirect_unit

Program-counter and control-flow redirect stage for the five-stage MIPS pipeline. It sits directly downstream of the ID-stage branch/jump comparator. Each cycle it consumes the comparator's Branch/Output pair, the ID instruction, its PC+4 and the forwarded rs value. It then owns the PC register, selects the next fetch address, flushes the IF/ID latch on a taken redirect, supplies the jal link address, and keeps saturating branch statistics.

## Interface
- RESET_PC, 32'h0000_0000, fetch address loaded on reset
- CNT_W, 16, width of the branch/taken statistics counters
- Clk  input  1  pipeline clock; all state updates on rising edge
- Rst  input  1  reset, asynchronous, active-low (0 = reset)
- Stall  input  1  hazard-unit stall; PC holds and redirects are ignored
- Instruction  input  32  ID-stage instruction word
- IDPC4  input  32  PC+4 of the ID-stage instruction
- RegA  input  32  forwarded rs value (jr target)
- Branch  input  1  comparator: ID instruction is a branch/jump
- Output  input  1  comparator: condition true / jump taken
- PC  output  32  current fetch address (registered)
- PCPlus4  output  32  PC + 4, modulo 2^32
- Flush  output  1  clear IF/ID latch this cycle (combinational)
- LinkWrite  output  1  write LinkAddr to $31 (jal taken, not stalled)
- LinkAddr  output  32  equals IDPC4
- Fault  output  1  sticky misaligned-target flag
- BranchCount  output  CNT_W  number of resolved branch/jump instructions
- TakenCount  output  CNT_W  number of taken redirects

## Operation
- Taken = Branch & Output. Output with Branch=0 is ignored.
- Target is selected by Instruction[31:26]:
  - 000101 (bne): IDPC4 + (sign-extended Instruction[15:0] << 2), modulo 2^32.
  - 000010/000011 (j/jal): {IDPC4[31:28], Instruction[25:0], 2'b00}.
  - 000000 with funct 001000 (jr): RegA.
- FSM states: BOOT, RUN, HALT; encoding is free.
- BOOT:
  - Entered on reset.
  - Flush=1; PC stays RESET_PC.
  - Moves to RUN on the next edge unconditionally, regardless of Stall.
- RUN, Stall=1: PC holds, Flush=0, LinkWrite=0, counters hold.
- RUN, Stall=0, Taken=0: PC <= PC+4. BranchCount increments if Branch=1.
- RUN, Stall=0, Taken=1, Target[1:0]==0:
  - PC <= Target; Flush=1.
  - BranchCount and TakenCount both increment.
  - LinkWrite=1 if opcode 000011.
- RUN, Stall=0, Taken=1, Target[1:0]!=0:
  - PC holds; Fault <= 1; next state HALT.
  - Flush=1; LinkWrite=0; counters do not increment.
- HALT: PC frozen, Flush=1 every cycle, counters frozen. Exits only on Rst.
- Counters saturate at all-ones (no wrap).
- PC+4 wraps: 32'hFFFF_FFFC -> 32'h0000_0000.

## Timing
- Reset (async, Rst=0):
  - PC=RESET_PC, Fault=0, BranchCount=0, TakenCount=0, state=BOOT.
  - Flush=1, LinkWrite=0, in the same instant (no clock edge needed).
- Rst release mid-cycle takes effect at the next rising edge. Reset asserted mid-redirect discards the redirect.
- Redirect latency: taken branch/jump resolved in ID at cycle n.
  - Flush=1 during cycle n kills the wrong-path IF instruction.
  - PC=Target from cycle n+1: one bubble per taken redirect.
- Not-taken branch: zero penalty, Flush=0.
- Flush, LinkWrite, LinkAddr and PCPlus4 are combinational from current state and inputs. PC, Fault and the counters are registered.
- Stall and Taken in the same cycle: Stall wins. The redirect is re-evaluated on the first non-stalled cycle with the then-current comparator inputs.

## Test plan
- Reset: Rst=0 then release with RESET_PC=0 -> PC=0, Flush=1 for exactly one cycle (BOOT), then PC=4, 8, 12 on successive cycles with Flush=0.
- Branch taken: bne, IDPC4=0x40, imm=0xFFFE, Branch=Output=1 -> Flush=1 that cycle, next PC=0x38, BranchCount=1, TakenCount=1. Then Branch=1, Output=0 -> PC+4, BranchCount=2, TakenCount=1.
- Jumps:
  - jal, IDPC4=0x1000_0010, target field 0x0000100 -> PC=0x1000_0400, LinkWrite=1, LinkAddr=0x1000_0010.
  - Then jr with RegA=0x1000_0010 -> PC=0x1000_0010, LinkWrite=0.
- Stall priority: Stall=1 with Taken=1 for 3 cycles -> PC constant, Flush=0, counters unchanged. Stall drops with Taken=1 -> redirect occurs on that cycle.
- Fault: jr with RegA=0x0000_0102 -> Fault=1, PC frozen, Flush=1 every cycle. Later Taken inputs are ignored. Rst=0 clears Fault, PC=RESET_PC.
- Saturation/wrap:
  - Force 65 540 taken redirects -> both counters stick at 0xFFFF.
  - Reset with RESET_PC=0xFFFF_FFFC, no branches -> PC reaches 0xFFFF_FFFC, then 0x0000_0000.
